// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared glyph table, seven-segment encoder and ALU state type
//
// Purpose: constants and helpers shared by the hex ALU top level and the
// digit scanner. Segment patterns are active-low, ordered abcdefg
// (bit 6 = a ... bit 0 = g).
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } alu_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed common-anode digit scanner
//
// Purpose: steps through DIGITS digit slots, REFRESH_DIV clocks per slot,
// driving the glyph of nibble k of value (or blank) on Seg with An[k] low.
// Ports:
//   Clock, Reset_n  - clock, asynchronous active-low reset
//   value           - DIGITS nibbles to display, nibble 0 = rightmost digit
//   blank           - per-digit blank request
//   Seg             - active-low segments abcdefg (registered)
//   An              - active-low one-hot digit enable (registered)
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [DIGITS*4-1:0]   value,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            Seg,
  output logic [DIGITS-1:0]     An
);

  localparam int                CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]     CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]        K_LAST   = 3'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RESET = ~(DIGITS'(1));

  logic [CW-1:0]     cnt;
  logic [2:0]        k;
  logic [2:0]        k_next;
  logic [3:0]        nib_next;
  logic              blank_next;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  // Everything for the following slot is prepared combinationally so that An
  // and Seg switch together on the wrap edge; a new value is therefore only
  // picked up at a slot boundary.
  always_comb begin
    k_next     = (k == K_LAST) ? 3'd0 : k + 3'd1;
    nib_next   = 4'h0;
    blank_next = 1'b0;
    an_next    = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (k_next == 3'(d)) begin
        nib_next   = value[d*4 +: 4];
        blank_next = blank[d];
        an_next[d] = 1'b0;
      end
    end
    seg_next = blank_next ? SEG_BLANK : hex_to_seg(nib_next);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
      k   <= 3'd0;
      An  <= AN_RESET;
      Seg <= SEG_0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      k   <= k_next;
      An  <= an_next;
      Seg <= seg_next;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hex_alu_display.sv
// rtl/hex_alu_display.sv - nibble-serial hex add/subtract with multiplexed 7-seg readout
//
// Purpose: on a rising edge of the Go button, captures A, B and Op and
// computes A+B or A-B one nibble per clock, then holds the result and scans
// it across DIGITS seven-segment displays.
// Ports:
//   Clock, Reset_n  - clock, asynchronous active-low reset
//   A, B            - WIDTH-bit operands (quasi-static switches)
//   Op              - 0 = add, 1 = subtract
//   Go              - asynchronous start button level
//   Busy            - nibbles being computed
//   Valid           - one-cycle pulse when Result updates
//   Result          - {carry/borrow, sum/difference}
//   Seg, An         - active-low segments and digit enables
module hex_alu_display
  import hex_display_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Op,
  input  logic              Go,
  output logic              Busy,
  output logic              Valid,
  output logic [WIDTH:0]    Result,
  output logic [6:0]        Seg,
  output logic [DIGITS-1:0] An
);

  localparam int         NIBBLES  = WIDTH / 4;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  // Go synchroniser and rising-edge detector.
  logic go_s1, go_s2, go_d;
  logic start;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_d  <= 1'b0;
    end else begin
      go_s1 <= Go;
      go_s2 <= go_s1;
      go_d  <= go_s2;
    end
  end

  assign start = go_s2 & ~go_d;

  alu_state_t       state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc;
  logic             op_reg;
  logic             carry;
  logic [2:0]       idx;
  logic [WIDTH:0]   result_r;
  logic             valid_r;

  logic             load, step, finish;
  logic [3:0]       a_nib, b_nib, b_eff;
  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] acc_next;

  // Nibble datapath: select nibble idx, add with carry, write it back into acc.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == 3'(n)) begin
        a_nib = a_reg[n*4 +: 4];
        b_nib = b_reg[n*4 +: 4];
      end
    end
    // Inversion kept at 4 bits so the adder does not see a sign-extended ~B.
    b_eff   = op_reg ? ~b_nib : b_nib;
    nib_sum = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry};
    acc_next = acc;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == 3'(n)) begin
        acc_next[n*4 +: 4] = nib_sum[3:0];
      end
    end
  end

  // Next-state logic. A start seen in CALC is dropped, never queued.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          load       = 1'b1;
        end
      end
      CALC: begin
        step = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= 1'b0;
      carry    <= 1'b0;
      idx      <= 3'd0;
      acc      <= '0;
      result_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      state   <= state_next;
      valid_r <= finish;
      if (load) begin
        a_reg  <= A;
        b_reg  <= B;
        op_reg <= Op;
        carry  <= Op;
        idx    <= 3'd0;
        acc    <= '0;
      end else if (step) begin
        acc   <= acc_next;
        carry <= nib_sum[4];
        idx   <= idx + 3'd1;
        if (finish) begin
          // Subtraction reports borrow, the complement of the final carry.
          result_r <= {(op_reg ? ~nib_sum[4] : nib_sum[4]), acc_next};
        end
      end
    end
  end

  assign Busy   = (state == CALC);
  assign Valid  = valid_r;
  assign Result = result_r;

  // Display value is Result zero-extended to the full digit count.
  logic [DIGITS*4-1:0] disp_value;
  logic [DIGITS-1:0]   blank;
  logic                upper_zero;

  always_comb begin
    disp_value          = '0;
    disp_value[WIDTH:0] = result_r;
  end

  // Walk from the top digit down; a digit is blank while it and every digit
  // above it is zero. Digit 0 always shows.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero & (disp_value[k*4 +: 4] == 4'h0);
      if ((BLANK_LZ != 0) && (k != 0)) begin
        blank[k] = upper_zero;
      end
    end
  end

  hex_display_scanner #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scanner (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .value   (disp_value),
    .blank   (blank),
    .Seg     (Seg),
    .An      (An)
  );

endmodule

// File: tb/tb_hex_alu_display.sv
// tb/tb_hex_alu_display.sv - scoreboard bench for hex_alu_display
module tb_hex_alu_display;

  localparam int WIDTH       = 8;
  localparam int DIGITS      = 3;
  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] G_0  = 7'b0000001;
  localparam logic [6:0] G_1  = 7'b1001111;
  localparam logic [6:0] G_7  = 7'b0001111;
  localparam logic [6:0] G_E  = 7'b0110000;
  localparam logic [6:0] G_F  = 7'b0111000;
  localparam logic [6:0] G_BL = 7'b1111111;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;
  logic       op    = 1'b0;
  logic       go    = 1'b0;

  logic       busy0, valid0, busy1, valid1;
  logic [8:0] res0, res1;
  logic [6:0] seg0, seg1;
  logic [2:0] an0, an1;

  int n_checks    = 0;
  int n_pass      = 0;
  int valid_count = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_r;

  always #5 clk = ~clk;

  hex_alu_display #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(1)
  ) dut0 (
    .Clock(clk), .Reset_n(rst_n), .A(a), .B(b), .Op(op), .Go(go),
    .Busy(busy0), .Valid(valid0), .Result(res0), .Seg(seg0), .An(an0)
  );

  hex_alu_display #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(0)
  ) dut1 (
    .Clock(clk), .Reset_n(rst_n), .A(a), .B(b), .Op(op), .Go(go),
    .Busy(busy1), .Valid(valid1), .Result(res1), .Seg(seg1), .An(an1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every Valid pulse consumes one expected result.
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_r = exp_q.pop_front();
        check("result_blz1", 32'(res0), 32'(exp_r));
        check("result_blz0", 32'(res1), 32'(exp_r));
        check("busy_low_with_valid", 32'(busy0), 32'd0);
        check("valid_both", 32'(valid1), 32'd1);
      end
    end
  end

  // Issue one operation, count Busy cycles, wait (bounded) for its Valid.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic opv,
                       input logic [8:0] expected, input string name);
    int vc;
    int busy_cycles;
    bit done;
    exp_q.push_back(expected);
    a  = av;
    b  = bv;
    op = opv;
    vc = valid_count;
    busy_cycles = 0;
    done = 1'b0;
    go = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2) go = 1'b0;
      if (busy0) busy_cycles++;
      if (valid_count > vc) begin
        done = 1'b1;
        break;
      end
    end
    go = 1'b0;
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd2);
  endtask

  // Let the new result reach the scanner, then capture one full scan.
  task automatic check_digits(input int inst, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input string name);
    logic [6:0] seen[3];
    logic [2:0] sel;
    logic [2:0] an;
    logic [6:0] seg;
    for (int d = 0; d < 3; d++) seen[d] = 7'bx;
    repeat (REFRESH_DIV) @(negedge clk);
    repeat (3 * REFRESH_DIV) begin
      @(negedge clk);
      an  = (inst == 0) ? an0 : an1;
      seg = (inst == 0) ? seg0 : seg1;
      for (int d = 0; d < 3; d++) begin
        sel = 3'b001 << d;
        if (an == ~sel) seen[d] = seg;
      end
    end
    check({name, "_d0"}, 32'(seen[0]), 32'(e0));
    check({name, "_d1"}, 32'(seen[1]), 32'(e1));
    check({name, "_d2"}, 32'(seen[2]), 32'(e2));
  endtask

  initial begin
    int vc;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vc;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_result", 32'(res0), 32'd0);
    check("rst_an", 32'(an0), 32'(3'b110));
    check("rst_seg", 32'(seg0), 32'(G_0));
    rst_n = 1'b1;

    // Scanner stepping with blank upper digits.
    @(negedge clk);
    check("scan_an_t1", 32'(an0), 32'(3'b110));
    repeat (3) @(negedge clk);
    check("scan_an_t4", 32'(an0), 32'(3'b101));
    check("scan_seg_t4", 32'(seg0), 32'(G_BL));
    repeat (4) @(negedge clk);
    check("scan_an_t8", 32'(an0), 32'(3'b011));
    check("scan_seg_t8", 32'(seg0), 32'(G_BL));
    repeat (4) @(negedge clk);
    check("scan_an_t12", 32'(an0), 32'(3'b110));
    check("scan_seg_t12", 32'(seg0), 32'(G_0));

    // FF + 01 -> carry out.
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    check_digits(0, G_0, G_0, G_1, "disp_100");

    // 05 - 07 -> borrow.
    do_op(8'h05, 8'h07, 1'b1, 9'h1FE, "sub_05_07");
    check_digits(0, G_E, G_F, G_1, "disp_1fe");

    // 03 + 04, with and without leading-zero blanking.
    do_op(8'h03, 8'h04, 1'b0, 9'h007, "add_03_04");
    check_digits(0, G_7, G_BL, G_BL, "disp_007_blz1");
    check_digits(1, G_7, G_0, G_0, "disp_007_blz0");

    // Held Go plus a re-pulse during Busy gives one operation; A changes after capture.
    repeat (5) @(negedge clk);
    vc = valid_count;
    exp_q.push_back(9'h046);
    a  = 8'h12;
    b  = 8'h34;
    op = 1'b0;
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    @(negedge clk) go = 1'b1;
    @(negedge clk) a  = 8'hFF;
    repeat (17) @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    check("hold_go_one_valid", 32'(valid_count - vc), 32'd1);
    check("hold_go_result", 32'(res0), 32'h046);

    // Reset during the second CALC cycle aborts the operation.
    a  = 8'h21;
    b  = 8'h10;
    go = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_before_abort", 32'(busy0), 32'd1);
    vc = valid_count;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_result", 32'(res0), 32'd0);
    check("abort_result_blz0", 32'(res1), 32'd0);
    @(negedge clk) go = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_valid", 32'(valid_count - vc), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
